// File: rtl/fetch_pkg.sv
// fetch_pkg: constants shared by the instruction-fetch stage and decode.
//   INSTR_BYTES      - byte stride between sequential instructions
//   NOP_WORD         - word placed in the IR when a fetch is flushed
//   RESET_PC_DEFAULT - default PC value loaded on reset
//   OP_J, OP_BNE     - opcode field values decode shares with this stage
package fetch_pkg;

    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam logic [5:0]  OP_BNE           = 6'b000101;

endpackage

// File: rtl/next_pc_logic.sv
// next_pc_logic: combinational next-PC selection for the fetch stage.
//   i_pc           - current PC
//   i_branch_taken - redirect to branch target
//   i_branch_base  - PC+4 of the branch (also supplies jump region bits)
//   i_branch_off   - raw 16-bit branch immediate
//   i_jump         - redirect to jump target (wins over branch)
//   i_jump_target  - raw 26-bit jump field
//   o_pc_plus4     - sequential successor of i_pc (wraps mod 2^32)
//   o_redirect     - a jump or taken branch is present
//   o_next_pc      - jump target, else branch target, else PC+4
module next_pc_logic
    import fetch_pkg::*;
(
    input  logic [31:0] i_pc,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_base,
    input  logic [15:0] i_branch_off,
    input  logic        i_jump,
    input  logic [25:0] i_jump_target,
    output logic [31:0] o_pc_plus4,
    output logic        o_redirect,
    output logic [31:0] o_next_pc
);

    logic [31:0] w_branch_tgt;
    logic [31:0] w_jump_tgt;

    assign o_pc_plus4   = i_pc + INSTR_BYTES;
    // Sign-extended word offset; low PC bits are never forced, so a
    // misaligned base produces a misaligned target.
    assign w_branch_tgt = i_branch_base + {{14{i_branch_off[15]}}, i_branch_off, 2'b00};
    assign w_jump_tgt   = {i_branch_base[31:28], i_jump_target, 2'b00};
    assign o_redirect   = i_jump | i_branch_taken;

    always_comb begin
        o_next_pc = o_pc_plus4;
        if (i_jump) begin
            o_next_pc = w_jump_tgt;
        end else if (i_branch_taken) begin
            o_next_pc = w_branch_tgt;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, drives it straight to
// the combinational instruction memory, registers the returned word into
// an IF/ID register and offers it to decode with a valid/ready handshake.
// Jumps and taken branches redirect the PC and flush the output register.
//   clk, reset     - clock, asynchronous active-high reset
//   readAddress    - PC register, byte address to instruction memory
//   instruction    - word returned for readAddress in the same cycle
//   instrOut       - registered instruction for decode
//   pcPlus4Out     - registered PC+4 of instrOut
//   outValid       - instrOut/pcPlus4Out hold a live instruction
//   outReady       - decode accepts the current output this cycle
//   branchTaken, branchBase, branchOffset - branch redirect request
//   jump, jumpTarget                      - jump redirect request
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] readAddress,
    input  logic [31:0] instruction,
    output logic [31:0] instrOut,
    output logic [31:0] pcPlus4Out,
    output logic        outValid,
    input  logic        outReady,
    input  logic        branchTaken,
    input  logic [31:0] branchBase,
    input  logic [15:0] branchOffset,
    input  logic        jump,
    input  logic [25:0] jumpTarget
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_pc_plus4;
    logic        r_valid;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;
    logic        w_redirect;
    logic        w_load;

    next_pc_logic u_next_pc (
        .i_pc           (r_pc),
        .i_branch_taken (branchTaken),
        .i_branch_base  (branchBase),
        .i_branch_off   (branchOffset),
        .i_jump         (jump),
        .i_jump_target  (jumpTarget),
        .o_pc_plus4     (w_pc_plus4),
        .o_redirect     (w_redirect),
        .o_next_pc      (w_next_pc)
    );

    // Output register is free when empty or being drained this cycle.
    assign w_load = !r_valid || outReady;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= RESET_PC;
            r_instr    <= NOP_WORD;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else if (w_redirect) begin
            // Word fetched this cycle is wrong-path; held output is dropped
            // regardless of outReady.
            r_pc    <= w_next_pc;
            r_instr <= NOP_WORD;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_pc       <= w_next_pc;
            r_instr    <= instruction;
            r_pc_plus4 <= w_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign readAddress = r_pc;
    assign instrOut    = r_instr;
    assign pcPlus4Out  = r_pc_plus4;
    assign outValid    = r_valid;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] readAddress;
    logic [31:0] instruction;
    logic [31:0] instrOut;
    logic [31:0] pcPlus4Out;
    logic        outValid;
    logic        outReady;
    logic        branchTaken;
    logic [31:0] branchBase;
    logic [15:0] branchOffset;
    logic        jump;
    logic [25:0] jumpTarget;

    int n_checks = 0;
    int n_errors = 0;

    // 32-byte instruction memory; address aliases every 32 bytes.
    logic [31:0] mem [8];

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_pp4;
    logic        m_valid;

    always #5 clk = ~clk;

    assign instruction = mem[readAddress[4:2]];

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .readAddress  (readAddress),
        .instruction  (instruction),
        .instrOut     (instrOut),
        .pcPlus4Out   (pcPlus4Out),
        .outValid     (outValid),
        .outReady     (outReady),
        .branchTaken  (branchTaken),
        .branchBase   (branchBase),
        .branchOffset (branchOffset),
        .jump         (jump),
        .jumpTarget   (jumpTarget)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_ir    = 32'h0;
        m_pp4   = 32'h0;
        m_valid = 1'b0;
    endtask

    // One clock edge of the fetch stage as described behaviourally.
    task automatic model_edge();
        logic [31:0] fetched;
        logic [31:0] off_bytes;
        fetched   = mem[m_pc[4:2]];
        off_bytes = 32'($signed(branchOffset)) * 32'd4;
        if (jump) begin
            m_pc    = {branchBase[31:28], jumpTarget, 2'b00};
            m_valid = 1'b0;
            m_ir    = 32'h0;
        end else if (branchTaken) begin
            m_pc    = branchBase + off_bytes;
            m_valid = 1'b0;
            m_ir    = 32'h0;
        end else if (!m_valid || outReady) begin
            m_ir    = fetched;
            m_pp4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic compare_model(input string tag);
        chk({tag, ".addr"}, readAddress, m_pc);
        chk({tag, ".valid"}, {31'h0, outValid}, {31'h0, m_valid});
        chk({tag, ".instr"}, instrOut, m_ir);
        if (m_valid) chk({tag, ".pp4"}, pcPlus4Out, m_pp4);
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        compare_model(tag);
    endtask

    task automatic idle_inputs();
        branchTaken  = 1'b0;
        jump         = 1'b0;
        branchBase   = 32'h0;
        branchOffset = 16'h0;
        jumpTarget   = 26'h0;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = $urandom;
        mem[0] = 32'h3653_0001;
        mem[1] = 32'h1660_0004;
        mem[6] = 32'h2272_0004;

        reset    = 1'b1;
        outReady = 1'b1;
        idle_inputs();
        model_reset();
        #8;
        chk("rst.addr", readAddress, 32'h0);
        chk("rst.valid", {31'h0, outValid}, 32'h0);
        chk("rst.instr", instrOut, 32'h0);
        chk("rst.pp4", pcPlus4Out, 32'h0);
        #4 reset = 1'b0;

        // Sequential fetch.
        cycle("seq1");
        chk("seq1.word", instrOut, 32'h3653_0001);
        chk("seq1.pp4c", pcPlus4Out, 32'd4);
        chk("seq1.addrc", readAddress, 32'd4);
        cycle("seq2");
        chk("seq2.word", instrOut, 32'h1660_0004);
        chk("seq2.pp4c", pcPlus4Out, 32'd8);
        chk("seq2.addrc", readAddress, 32'd8);

        // Three-cycle stall holding 0x16600004.
        outReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle("stall");
            chk("stall.word", instrOut, 32'h1660_0004);
            chk("stall.addrc", readAddress, 32'd8);
            chk("stall.validc", {31'h0, outValid}, 32'h1);
        end
        outReady = 1'b1;
        cycle("resume");
        chk("resume.pp4c", pcPlus4Out, 32'd12);

        // Taken branch: 8 + (4<<2) = 24.
        branchTaken = 1'b1; branchBase = 32'd8; branchOffset = 16'd4;
        cycle("br");
        chk("br.addrc", readAddress, 32'd24);
        chk("br.bubble", {31'h0, outValid}, 32'h0);
        idle_inputs();
        cycle("br.tgt");
        chk("br.word", instrOut, 32'h2272_0004);
        chk("br.pp4c", pcPlus4Out, 32'd28);

        // Jump and branch together: jump wins.
        jump = 1'b1; branchTaken = 1'b1; jumpTarget = 26'h0;
        branchBase = 32'd32; branchOffset = 16'd4;
        cycle("jmp");
        chk("jmp.addrc", readAddress, 32'h0);
        chk("jmp.bubble", {31'h0, outValid}, 32'h0);
        idle_inputs();
        cycle("jmp.tgt");
        chk("jmp.word", instrOut, 32'h3653_0001);

        // Redirect while stalled flushes the held word.
        outReady = 1'b0;
        cycle("rs.hold");
        branchTaken = 1'b1; branchBase = 32'h0; branchOffset = 16'd2;
        cycle("rs.flush");
        chk("rs.addrc", readAddress, 32'd8);
        chk("rs.validc", {31'h0, outValid}, 32'h0);

        // Branch to 0xFFFFFFFC, then sequential wrap to 0.
        branchBase = 32'h0; branchOffset = 16'hFFFF;
        cycle("wrap.br");
        chk("wrap.top", readAddress, 32'hFFFF_FFFC);
        idle_inputs();
        outReady = 1'b1;
        cycle("wrap.inc");
        chk("wrap.zero", readAddress, 32'h0);
        chk("wrap.pp4c", pcPlus4Out, 32'h0);

        // Async reset mid-cycle during a stall.
        outReady = 1'b0;
        cycle("ar.stall");
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("ar.addr", readAddress, 32'h0);
        chk("ar.valid", {31'h0, outValid}, 32'h0);
        chk("ar.instr", instrOut, 32'h0);
        chk("ar.pp4", pcPlus4Out, 32'h0);
        #2 reset = 1'b0;
        outReady = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            outReady    = ($urandom_range(0, 9) < 7);
            branchTaken = ($urandom_range(0, 9) == 0);
            jump        = ($urandom_range(0, 19) == 0);
            branchBase  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            branchOffset = 16'($urandom);
            jumpTarget   = 26'($urandom);
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the single-cycle/pipelined MIPS datapath. It holds the program counter and drives `readAddress` into the combinational instruction memory. It captures the returned 32-bit word into an IF/ID output register and hands it to decode over a valid/ready handshake. Redirects for taken branches and jumps arrive from decode and flush the wrong-path word.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `readAddress`  out  32  byte address to instruction memory; always equals PC register
- `instruction`  in  32  word returned by instruction memory, same cycle as `readAddress`
- `instrOut`  out  32  registered instruction for decode
- `pcPlus4Out`  out  32  registered PC+4 of `instrOut`
- `outValid`  out  1  `instrOut`/`pcPlus4Out` hold a live instruction
- `outReady`  in  1  decode accepts the current output this cycle
- `branchTaken`  in  1  redirect to branch target
- `branchBase`  in  32  PC+4 of the branch instruction
- `branchOffset`  in  16  raw immediate field of the branch
- `jump`  in  1  redirect to jump target
- `jumpTarget`  in  26  raw target field of the jump

## Operation
- Reset (async, any time, including mid-stall or mid-redirect): PC=`RESET_PC`, `instrOut`=0, `pcPlus4Out`=0, `outValid`=0. `readAddress` follows PC immediately.
- Transfer: `outValid && outReady`.
- Load condition: `!outValid || outReady`. When true and no redirect, the IR captures `instruction`, `pcPlus4Out`←PC+4, `outValid`←1, PC←PC+4.
- Stall (`outValid && !outReady`, no redirect): PC, IR, `pcPlus4Out`, `outValid` all hold. `readAddress` is stable.
- Redirect (`jump || branchTaken`) has priority over stall and load:
  - PC←target.
  - `outValid`←0 and `instrOut`←0 (NOP). This flushes the word fetched this cycle.
  - The held output is discarded, whether or not `outReady` is high.
- Target arithmetic (all mod 2^32, no overflow detection):
  - branch target = `branchBase` + (sign-extend(`branchOffset`) << 2)
  - jump target = {`branchBase`[31:28], `jumpTarget`, 2'b00}
- `jump` and `branchTaken` both high: jump wins.
- PC increment wraps 32'hFFFF_FFFC → 32'h0000_0000. The memory itself truncates the address to 5 bits, so fetch addresses alias every 32 bytes.
- PC[1:0] is never forced. A misaligned target passes through unmodified.

## Timing
- Latency: PC presented on `readAddress` in cycle N. The word appears on `instrOut` with `outValid`=1 after edge N.
- Throughput: one instruction per cycle while `outReady`=1.
- First fetch after reset release: `readAddress`=`RESET_PC` in the first cycle. `outValid` rises on the first clock edge.
- Redirect seen at edge N:
  - `outValid`=0 in cycle N+1.
  - Target word is valid in cycle N+2.
  - Redirect penalty is one bubble.
- Back-to-back redirects: each redirect overrides the previous. `outValid` stays 0 until a cycle with no redirect.
- No combinational path from `outReady`, `jump` or `branchTaken` to `readAddress`. All outputs are registered except `readAddress`, which is driven by the PC flop.

## Structure
- Package `fetch_pkg`:
  - `INSTR_BYTES`=4
  - `NOP_WORD`=32'h0000_0000
  - default `RESET_PC`
  - opcode constants `OP_J`=6'b000010, `OP_BNE`=6'b000101 (shared with decode)
- Sub-module `next_pc_logic`: purely combinational. Computes PC+4, the branch target, the jump target, and the priority select.
- `fetch_unit` holds the PC register, the IR, `pcPlus4Out`, `outValid` and the handshake logic.

## Test plan
- Reset then run with `outReady`=1, memory words 0x36530001 @0 and 0x16600004 @4:
  - `readAddress` goes 0, 4, 8.
  - `instrOut` = 0x36530001 then 0x16600004.
  - `pcPlus4Out` = 4 then 8.
- Stall: drop `outReady` for 3 cycles while `instrOut`=0x16600004. Output, `readAddress`=8 and `outValid` hold. The sequence resumes with no loss or duplication.
- Branch: `branchTaken`=1, `branchBase`=8, `branchOffset`=4 → PC=24. One bubble (`outValid`=0). Next `instrOut`=0x22720004, `pcPlus4Out`=28.
- Jump: `jump`=1, `jumpTarget`=0, `branchBase`=32 → PC=0, one bubble. Same cycle with `branchTaken`=1 as well: jump still wins, PC=0.
- Redirect during stall (`outValid`=1, `outReady`=0): the held word is flushed, `outValid`=0, and PC loads the target.
- Async reset asserted mid-cycle during a stall: all outputs zero and `readAddress`=`RESET_PC` without a clock edge. The PC wrap from 32'hFFFF_FFFC gives 0.
